// File: rtl/bcd_disp_pkg.sv
// Shared segment constants for the multiplexed BCD display driver.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; dp bit is left off (1) here.
package bcd_disp_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Non-decimal codes (A-F) show a dash so a corrupted counter is visible.
  function automatic logic [7:0] bcd_seg_code(input logic [3:0] bcd);
    logic [7:0] code;
    code = SEG_DASH;
    case (bcd)
      4'd0: code = SEG_0;
      4'd1: code = SEG_1;
      4'd2: code = SEG_2;
      4'd3: code = SEG_3;
      4'd4: code = SEG_4;
      4'd5: code = SEG_5;
      4'd6: code = SEG_6;
      4'd7: code = SEG_7;
      4'd8: code = SEG_8;
      4'd9: code = SEG_9;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to seven-segment decoder (active-low {g,f,e,d,c,b,a}).
// Digits A-F decode to a dash (segment g only).
module bcd_to_sseg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  logic [7:0] w_code;

  assign w_code = bcd_seg_code(i_bcd);
  assign o_seg  = w_code[6:0];

endmodule

// File: rtl/bcd_disp_mux.sv
// Four-digit time-multiplexed common-anode display driver with per-frame snapshot.
// Optional leading-zero blanking is enabled by defining BCD_DISP_LZB_EN.
module bcd_disp_mux
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  logic [REFRESH_BITS-1:0] r_q;
  logic [3:0][3:0]         r_dig;
  logic [3:0]              r_dp;
  logic [3:0]              r_an;
  logic [7:0]              r_sseg;
  logic                    r_tick;

  logic                    w_wrap;
  logic [1:0]              w_sel;
  logic [3:0]              w_dig;
  logic [6:0]              w_seg7;
  logic                    w_blank;
  logic [3:0]              w_an_next;
  logic [7:0]              w_seg_next;

  assign w_wrap = &r_q;
  assign w_sel  = r_q[REFRESH_BITS-1 -: 2];
  assign w_dig  = r_dig[w_sel];

  // Prescaler and frame snapshot; the wrap edge captures whatever is on the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= '0;
      r_dig <= '0;
      r_dp  <= '0;
    end else begin
      r_q <= r_q + 1'b1;
      if (w_wrap) begin
        r_dig <= {d3, d2, d1, d0};
        r_dp  <= dp_in;
      end
    end
  end

  bcd_to_sseg u_dec (
    .i_bcd (w_dig),
    .o_seg (w_seg7)
  );

`ifdef BCD_DISP_LZB_EN
  // A slot is a leading zero only if it and every more significant digit are zero.
  always_comb begin
    w_blank = 1'b0;
    case (w_sel)
      2'd3: w_blank = (r_dig[3] == 4'd0);
      2'd2: w_blank = (r_dig[3] == 4'd0) && (r_dig[2] == 4'd0);
      2'd1: w_blank = (r_dig[3] == 4'd0) && (r_dig[2] == 4'd0) && (r_dig[1] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_an_next  = w_blank ? AN_OFF : ~(4'b0001 << w_sel);
  assign w_seg_next = w_blank ? SEG_BLANK : {~r_dp[w_sel], w_seg7};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an   <= AN_OFF;
      r_sseg <= SEG_BLANK;
      r_tick <= 1'b0;
    end else begin
      r_an   <= w_an_next;
      r_sseg <= w_seg_next;
      r_tick <= w_wrap;
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Directed plus random stimulus for bcd_disp_mux at REFRESH_BITS=4 against an
// edge-counting reference model; honours BCD_DISP_LZB_EN if defined.
module tb_bcd_disp_mux;

  localparam int RB = 4;
  localparam int FR = 1 << RB;
  localparam int SL = FR / 4;

  logic       clk;
  logic       reset;
  logic [3:0] d3, d2, d1, d0, dp_in;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  int total;
  int bad;
  int e;
  logic [3:0] m_d [4];
  logic [3:0] m_dp;

  bcd_disp_mux #(.REFRESH_BITS(RB)) dut (
    .clk        (clk),
    .reset      (reset),
    .d3         (d3),
    .d2         (d2),
    .d1         (d1),
    .d0         (d0),
    .dp_in      (dp_in),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [7:0] t [10];
    logic [7:0] c;
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    c = (v > 4'd9) ? 8'hBF : t[v];
    return c[6:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%h exp=%h", tag, e, got, exp);
    end
  endtask

  task automatic set_digits(input logic [3:0] a3, input logic [3:0] a2,
                            input logic [3:0] a1, input logic [3:0] a0,
                            input logic [3:0] p);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0; dp_in = p;
  endtask

  // Model: edge e sees q=(e-1) mod FR; outputs after edge e show that slot from
  // the snapshot held before e; edges with e mod FR == 0 capture the inputs.
  task automatic cyc();
    int s;
    logic blank;
    logic [3:0] x_an;
    logic [7:0] x_seg;
    logic x_tick;
    @(posedge clk);
    e++;
    s = ((e - 1) % FR) / SL;
    blank = 1'b0;
`ifdef BCD_DISP_LZB_EN
    if (s != 0) begin
      blank = 1'b1;
      for (int k = s; k < 4; k++) if (m_d[k] != 4'd0) blank = 1'b0;
    end
`endif
    x_an   = blank ? 4'b1111 : (4'b1111 & ~(4'b0001 << s));
    x_seg  = blank ? 8'hFF : {~m_dp[s], ref_seg(m_d[s])};
    x_tick = (e % FR == 0);
    if (e % FR == 0) begin
      m_d[0] = d0; m_d[1] = d1; m_d[2] = d2; m_d[3] = d3;
      m_dp = dp_in;
    end
    #1;
    check("an", {4'h0, an}, {4'h0, x_an});
    check("sseg", sseg, x_seg);
    check("frame_tick", {7'h0, frame_tick}, {7'h0, x_tick});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic model_reset();
    e = 0;
    for (int k = 0; k < 4; k++) m_d[k] = 4'd0;
    m_dp = 4'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    reset = 1'b1;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_sseg", sseg, 8'hFF);
    check("rst_tick", {7'h0, frame_tick}, 8'h00);

    // Release away from the edge; first frame shows the all-zero reset shadow.
    @(negedge clk);
    reset = 1'b0;
    run(3 * FR);

    // Mid-frame change must not appear until the next snapshot.
    while (e % FR != 6) cyc();
    d0 = 4'd5;
    run(2 * FR);

    set_digits(4'd4, 4'd3, 4'hC, 4'd1, 4'b0100);
    run(2 * FR + 3);

    set_digits(4'd0, 4'd0, 4'd0, 4'd7, 4'b1110);
    run(2 * FR);
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0001);
    run(2 * FR);
    set_digits(4'd0, 4'd5, 4'd0, 4'd0, 4'd0);
    run(2 * FR);

    // Random digits (including A-F) changed at random phases.
    for (int r = 0; r < 12; r++) begin
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
      run($urandom_range(3, 30));
    end

    // Change inputs right before the wrap edge: the wrap edge must capture them.
    while (e % FR != FR - 1) cyc();
    set_digits(4'd9, 4'd8, 4'd6, 4'd2, 4'b1001);
    run(FR + 2);

    // Asynchronous reset in mid-frame, checked before any clock edge.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111);
    while (e % FR != 5) cyc();
    #2;
    reset = 1'b1;
    #1;
    check("arst_an", {4'h0, an}, 8'h0F);
    check("arst_sseg", sseg, 8'hFF);
    check("arst_tick", {7'h0, frame_tick}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run(2 * FR + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout edge=%0d", e);
    $fatal(1, "timeout");
  end

endmodule
